// File: rtl/morphle_pkg.sv
// Shared definitions for the Morphle Logic configuration path.
// Holds the cell code constants and the loader/shifter state encodings.
package morphle_pkg;

  localparam int unsigned CFG_W = 3;

  localparam logic [CFG_W-1:0] CFG_SPACE = 3'b000;
  localparam logic [CFG_W-1:0] CFG_PLUS  = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETUP,
    ST_HIGH,
    ST_DONE
  } loader_state_e;

  // Per-bit phase of the confclk generator.
  typedef enum logic [1:0] {
    PH_OFF,
    PH_SETUP,
    PH_HIGH
  } phase_e;

endpackage

// File: rtl/ycconfig_shifter.sv
// Single-bit confclk generator: DIV cycles low (setup) then DIV cycles high.
// A bit_go on the last high cycle chains straight into the next bit.
module ycconfig_shifter
  import morphle_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_go,
  output logic confclk,
  output logic sample,
  output logic bit_done
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  phase_e            phase, phase_next;
  logic [DIV_W-1:0]  cnt, cnt_next;
  logic              phase_end;

  assign phase_end = (cnt == DIV_LAST);
  assign sample    = (phase == PH_SETUP) && phase_end;
  assign bit_done  = (phase == PH_HIGH) && phase_end;

  // Phase sequencing; the divider restarts at every phase boundary.
  always_comb begin
    phase_next = phase;
    cnt_next   = cnt;
    case (phase)
      PH_OFF: begin
        if (bit_go) begin
          phase_next = PH_SETUP;
          cnt_next   = '0;
        end
      end
      PH_SETUP: begin
        if (phase_end) begin
          phase_next = PH_HIGH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + DIV_W'(1);
        end
      end
      PH_HIGH: begin
        if (phase_end) begin
          phase_next = bit_go ? PH_SETUP : PH_OFF;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + DIV_W'(1);
        end
      end
      default: begin
        phase_next = PH_OFF;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase   <= PH_OFF;
      cnt     <= '0;
      confclk <= 1'b0;
    end else begin
      phase   <= phase_next;
      cnt     <= cnt_next;
      confclk <= (phase_next == PH_HIGH);
    end
  end

endmodule

// File: rtl/ycconfig_loader.sv
// Programs a serial ycconfig chain from a handshaked stream of 3-bit codes,
// MSB first, and returns the displaced chain contents cell by cell.
module ycconfig_loader
  import morphle_pkg::*;
#(
  parameter int unsigned CELLS = 16,
  parameter int unsigned DIV   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CFG_W-1:0] in_data,
  output logic             rd_valid,
  output logic [CFG_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             confclk,
  output logic             cbitin,
  input  logic             cbitout
);

  localparam int unsigned CELL_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [CELL_W-1:0] CELL_LAST = CELL_W'(CELLS - 1);

  loader_state_e     state, state_next;
  logic [1:0]        bit_cnt, bit_cnt_next;
  logic [CELL_W-1:0] cell_cnt, cell_cnt_next;
  logic [CFG_W-1:0]  code, code_next;
  logic [CFG_W-1:0]  rd_data_next;
  logic              rd_valid_next;
  logic              cbitin_next;
  logic              bit_go;
  logic              sample;
  logic              bit_done;

  ycconfig_shifter #(.DIV(DIV)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .bit_go   (bit_go),
    .confclk  (confclk),
    .sample   (sample),
    .bit_done (bit_done)
  );

  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    cell_cnt_next = cell_cnt;
    code_next     = code;
    rd_data_next  = rd_data;
    rd_valid_next = 1'b0;
    bit_go        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next    = ST_FETCH;
          cell_cnt_next = '0;
        end
      end
      ST_FETCH: begin
        if (in_valid && in_ready) begin
          code_next    = in_data;
          bit_cnt_next = 2'd0;
          bit_go       = 1'b1;
          state_next   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // Capture the far-end bit just before the confclk rise shifts it away.
        if (sample) begin
          rd_data_next = {rd_data[CFG_W-2:0], cbitout};
          state_next   = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (bit_done) begin
          if (bit_cnt < 2'd2) begin
            code_next    = {code[CFG_W-2:0], 1'b0};
            bit_cnt_next = bit_cnt + 2'd1;
            bit_go       = 1'b1;
            state_next   = ST_SETUP;
          end else begin
            rd_valid_next = 1'b1;
            if (cell_cnt < CELL_LAST) begin
              cell_cnt_next = cell_cnt + CELL_W'(1);
              state_next    = ST_FETCH;
            end else begin
              state_next = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    // cbitin moves only when a new bit enters its setup phase.
    cbitin_next = bit_go ? code_next[CFG_W-1] : cbitin;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      bit_cnt  <= 2'd0;
      cell_cnt <= '0;
      code     <= CFG_SPACE;
      rd_data  <= CFG_SPACE;
      rd_valid <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cbitin   <= 1'b0;
    end else begin
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      cell_cnt <= cell_cnt_next;
      code     <= code_next;
      rd_data  <= rd_data_next;
      rd_valid <= rd_valid_next;
      in_ready <= (state_next == ST_FETCH);
      busy     <= (state_next != ST_IDLE);
      done     <= (state_next == ST_DONE);
      cbitin   <= cbitin_next;
    end
  end

endmodule

// File: tb/tb_ycconfig_loader.sv
// Directed bench for ycconfig_loader driving behavioural ycconfig chains.
// Instance a: CELLS=2, DIV=2. Instance b: CELLS=1, DIV=1.
module tb_ycconfig_loader;
  import morphle_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       a_start, a_in_valid, a_in_ready, a_rd_valid, a_busy, a_done;
  logic       a_confclk, a_cbitin, a_cbitout;
  logic [2:0] a_in_data, a_rd_data;
  logic       b_start, b_in_valid, b_in_ready, b_rd_valid, b_busy, b_done;
  logic       b_confclk, b_cbitin, b_cbitout;
  logic [2:0] b_in_data, b_rd_data;

  int errors = 0;
  int checks = 0;

  ycconfig_loader #(.CELLS(2), .DIV(2)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .in_data(a_in_data), .rd_valid(a_rd_valid),
    .rd_data(a_rd_data), .busy(a_busy), .done(a_done), .confclk(a_confclk),
    .cbitin(a_cbitin), .cbitout(a_cbitout)
  );

  ycconfig_loader #(.CELLS(1), .DIV(1)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_data(b_in_data), .rd_valid(b_rd_valid),
    .rd_data(b_rd_data), .busy(b_busy), .done(b_done), .confclk(b_confclk),
    .cbitin(b_cbitin), .cbitout(b_cbitout)
  );

  // Behavioural chains: shift on confclk rise, far end drives cbitout.
  logic [5:0] chain_a = '0;
  always @(posedge a_confclk) chain_a <= {chain_a[4:0], a_cbitin};
  assign a_cbitout = chain_a[5];

  logic [2:0] chain_b = '0;
  logic [2:0] b_log = '0;
  int         b_rises = 0;
  always @(posedge b_confclk) begin
    chain_b <= {chain_b[1:0], b_cbitin};
    b_log   <= {b_log[1:0], b_cbitin};
    b_rises <= b_rises + 1;
  end
  assign b_cbitout = chain_b[2];

  logic [2:0] a_rd_q [0:15];
  int a_rd_n = 0;
  int a_done_n = 0;
  int a_acc_n = 0;
  always @(posedge clk) begin
    if (a_rd_valid && a_rd_n < 16) begin
      a_rd_q[a_rd_n] <= a_rd_data;
      a_rd_n <= a_rd_n + 1;
    end
    if (a_done) a_done_n <= a_done_n + 1;
    if (a_in_valid && a_in_ready) a_acc_n <= a_acc_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a_wait_ready();
    int n = 0;
    while (a_in_ready !== 1'b1 && n < 100) begin tick(); n++; end
    chk("a_ready_timeout", 32'(n < 100), 32'd1);
  endtask

  task automatic a_push(input logic [2:0] c);
    a_wait_ready();
    a_in_data  = c;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic a_wait_done();
    int n = 0;
    while (a_done !== 1'b1 && n < 200) begin tick(); n++; end
    chk("a_done_timeout", 32'(n < 200), 32'd1);
    tick();
  endtask

  task automatic a_wait_cc(input logic lvl);
    int n = 0;
    while (a_confclk !== lvl && n < 100) begin tick(); n++; end
    chk("a_confclk_wait", 32'(n < 100), 32'd1);
  endtask

  task automatic a_kick();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  initial begin
    int lat;
    int bad;
    reset = 1'b1;
    a_start = 1'b0; a_in_valid = 1'b0; a_in_data = 3'b000;
    b_start = 1'b0; b_in_valid = 1'b0; b_in_data = 3'b000;
    tick();
    tick();
    chk("a_reset_outs", 32'({a_confclk, a_cbitin, a_in_ready, a_rd_valid, a_busy, a_done, a_rd_data}), 32'd0);
    chk("b_reset_outs", 32'({b_confclk, b_cbitin, b_in_ready, b_rd_valid, b_busy, b_done, b_rd_data}), 32'd0);
    reset = 1'b0;
    tick();

    // Single cell, DIV=1: load '+' and time the done pulse from the accept.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("b_ready_after_start", 32'(b_in_ready), 32'd1);
    b_in_data  = CFG_PLUS;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    chk("b_ready_drop", 32'(b_in_ready), 32'd0);
    lat = 1;
    while (b_done !== 1'b1 && lat < 30) begin tick(); lat++; end
    chk("b_done_latency", 32'(lat), 32'd7);
    chk("b_rd_valid", 32'(b_rd_valid), 32'd1);
    chk("b_rd_data", 32'(b_rd_data), 32'(CFG_SPACE));
    chk("b_cbitin_seq", 32'(b_log), 32'b001);
    chk("b_rises", 32'(b_rises), 32'd3);
    chk("b_chain", 32'(chain_b), 32'(CFG_PLUS));
    tick();
    chk("b_idle_after", 32'({b_done, b_busy, b_confclk}), 32'd0);

    // Two cells, DIV=2: load '+',space with a 10-cycle stall between cells.
    a_start = 1'b1;
    chk("a_ready_before_edge", 32'(a_in_ready), 32'd0);
    tick();
    a_start = 1'b0;
    chk("a_ready_after_start", 32'(a_in_ready), 32'd1);
    chk("a_busy_after_start", 32'(a_busy), 32'd1);
    a_push(CFG_PLUS);
    a_wait_ready();
    bad = 0;
    repeat (10) begin
      tick();
      if (a_confclk !== 1'b0 || a_busy !== 1'b1 || a_in_ready !== 1'b1) bad++;
    end
    chk("a_stall", 32'(bad), 32'd0);
    a_push(CFG_SPACE);
    a_wait_done();
    chk("a_load1_rd_n", 32'(a_rd_n), 32'd2);
    chk("a_load1_rd0", 32'(a_rd_q[0]), 32'b000);
    chk("a_load1_rd1", 32'(a_rd_q[1]), 32'b000);
    chk("a_load1_chain", 32'(chain_a), 32'b001000);
    chk("a_load1_done_n", 32'(a_done_n), 32'd1);

    // Reload spaces: previous contents come back far cell first.
    a_kick();
    a_push(CFG_SPACE);
    a_push(CFG_SPACE);
    a_wait_done();
    chk("a_load2_rd_n", 32'(a_rd_n), 32'd4);
    chk("a_load2_rd0", 32'(a_rd_q[2]), 32'b001);
    chk("a_load2_rd1", 32'(a_rd_q[3]), 32'b000);
    chk("a_load2_chain", 32'(chain_a), 32'b000000);
    chk("a_load2_done_n", 32'(a_done_n), 32'd2);

    // Reset during the second high phase of cell 0 leaves two bits shifted.
    a_kick();
    a_push(3'b101);
    a_wait_cc(1'b1);
    a_wait_cc(1'b0);
    a_wait_cc(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("a_rst_confclk", 32'(a_confclk), 32'd0);
    chk("a_rst_busy", 32'(a_busy), 32'd0);
    chk("a_rst_chain", 32'(chain_a), 32'b000010);

    // Fresh load with a start pulse while busy; must still be exactly two cells.
    a_kick();
    a_push(3'b010);
    a_kick();
    a_push(3'b011);
    a_wait_done();
    chk("a_load3_rd_n", 32'(a_rd_n), 32'd6);
    chk("a_load3_rd0", 32'(a_rd_q[4]), 32'b000);
    chk("a_load3_rd1", 32'(a_rd_q[5]), 32'b010);
    chk("a_load3_chain", 32'(chain_a), 32'b010011);
    chk("a_load3_done_n", 32'(a_done_n), 32'd3);

    // in_valid held in IDLE is never accepted.
    a_in_data  = 3'b111;
    a_in_valid = 1'b1;
    bad = 0;
    repeat (5) begin
      tick();
      if (a_in_ready !== 1'b0 || a_busy !== 1'b0) bad++;
    end
    a_in_valid = 1'b0;
    chk("a_idle_valid", 32'(bad), 32'd0);
    chk("a_acc_n", 32'(a_acc_n), 32'd7);
    chk("a_idle_done_n", 32'(a_done_n), 32'd3);
    chk("a_idle_chain", 32'(chain_a), 32'b010011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
